mips_single_cycle_core: RTL and testbench



---
 rtl/mips_single_cycle_core.sv | 233 +++++++++++++++++++++++
 tb/tb_mips_single_cycle_core.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_single_cycle_core.sv
// Single-cycle 32-bit MIPS core: PC, imem, regfile, ALU, control, dmem.
// Every instruction fetches, executes and commits on one rising edge.

module pc (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_next,
  output logic [31:0] pc_out
);
  // Program counter, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_out <= '0;
    else       pc_out <= pc_next;
  end
endmodule

module instruction_memory #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [29:0]   widx,
  output logic [31:0]   instr
);
  logic [31:0] memory [0:DEPTH-1];

  // Loader write port; tied off in the core, programs arrive by backdoor
  always_ff @(posedge clk) begin
    if (we) memory[waddr] <= wdata;
  end

  // Combinational fetch, past-the-end words read as NOP
  always_comb begin
    instr = '0;
    if (widx < 30'(DEPTH)) instr = memory[widx[AW-1:0]];
  end
endmodule

module register_file (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] registers [0:31];

  // Single write port; $0 is never written
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) registers[i] <= '0;
    end else if (we && wa != 5'd0) begin
      registers[wa] <= wd;
    end
  end

  // Two combinational read ports, $0 hardwired to zero
  always_comb begin
    rd1 = (ra1 == 5'd0) ? 32'd0 : registers[ra1];
    rd2 = (ra2 == 5'd0) ? 32'd0 : registers[ra2];
  end
endmodule

module data_memory #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  logic [31:0] memory [0:DEPTH-1];
  logic        inr;

  assign inr = addr < 32'(DEPTH);

  // Word-addressed store; out-of-range stores vanish
  always_ff @(posedge clk) begin
    if (we && inr) memory[addr[AW-1:0]] <= wdata;
  end

  // Combinational load, out-of-range reads zero
  always_comb begin
    rdata = '0;
    if (inr) rdata = memory[addr[AW-1:0]];
  end
endmodule

module mips_single_cycle_core #(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input  logic clk,
  input  logic reset
);
  localparam int IAW = $clog2(IMEM_DEPTH);

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
  } alu_t;

  logic [31:0] pc_cur, pc_next, pc_plus4;
  logic [31:0] instr, imm, rd1, rd2;
  logic [31:0] alu_b, alu_y, rdata, wd;
  logic [4:0]  wa;
  logic        regwrite, regdst, alusrc;
  logic        memwrite, memtoreg;
  logic        branch, jump, zero;
  alu_t        aluc;

  pc pc_inst (
    .clk     (clk),
    .reset   (reset),
    .pc_next (pc_next),
    .pc_out  (pc_cur)
  );

  instruction_memory #(.DEPTH(IMEM_DEPTH)) instruction_memory_inst (
    .clk   (clk),
    .we    (1'b0),
    .waddr ({IAW{1'b0}}),
    .wdata (32'd0),
    .widx  (pc_cur[31:2]),
    .instr (instr)
  );

  register_file register_file_inst (
    .clk   (clk),
    .reset (reset),
    .we    (regwrite),
    .ra1   (instr[25:21]),
    .ra2   (instr[20:16]),
    .wa    (wa),
    .wd    (wd),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  data_memory #(.DEPTH(DMEM_DEPTH)) data_memory_inst (
    .clk   (clk),
    .we    (memwrite),
    .addr  (alu_y),
    .wdata (rd2),
    .rdata (rdata)
  );

  // Main and ALU control; unknown op/funct fall through as NOP
  always_comb begin
    regwrite = 1'b0;
    regdst   = 1'b0;
    alusrc   = 1'b0;
    memwrite = 1'b0;
    memtoreg = 1'b0;
    branch   = 1'b0;
    jump     = 1'b0;
    aluc     = ALU_ADD;
    unique case (instr[31:26])
      6'b000000: begin
        regdst = 1'b1;
        unique case (instr[5:0])
          6'b100000: begin regwrite = 1'b1; aluc = ALU_ADD; end
          6'b100010: begin regwrite = 1'b1; aluc = ALU_SUB; end
          6'b100100: begin regwrite = 1'b1; aluc = ALU_AND; end
          6'b100101: begin regwrite = 1'b1; aluc = ALU_OR;  end
          6'b101010: begin regwrite = 1'b1; aluc = ALU_SLT; end
          default: ;
        endcase
      end
      6'b100011: begin
        regwrite = 1'b1;
        alusrc   = 1'b1;
        memtoreg = 1'b1;
      end
      6'b101011: begin
        alusrc   = 1'b1;
        memwrite = 1'b1;
      end
      6'b000100: begin
        branch = 1'b1;
        aluc   = ALU_SUB;
      end
      6'b001000: begin
        regwrite = 1'b1;
        alusrc   = 1'b1;
      end
      6'b000010: jump = 1'b1;
      default: ;
    endcase
  end

  assign imm   = {{16{instr[15]}}, instr[15:0]};
  assign alu_b = alusrc ? imm : rd2;

  // ALU, wraparound arithmetic and signed set-less-than
  always_comb begin
    alu_y = '0;
    unique case (aluc)
      ALU_ADD: alu_y = rd1 + alu_b;
      ALU_SUB: alu_y = rd1 - alu_b;
      ALU_AND: alu_y = rd1 & alu_b;
      ALU_OR:  alu_y = rd1 | alu_b;
      ALU_SLT: alu_y = {31'd0, $signed(rd1) < $signed(alu_b)};
      default: alu_y = '0;
    endcase
  end

  assign zero = (alu_y == 32'd0);
  assign wa   = regdst ? instr[15:11] : instr[20:16];
  assign wd   = memtoreg ? rdata : alu_y;

  assign pc_plus4 = pc_cur + 32'd4;

  // Next-PC select: jump, taken branch, or fall through
  always_comb begin
    pc_next = pc_plus4;
    unique case (1'b1)
      jump:
        pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
      branch && zero:
        pc_next = pc_plus4 + {imm[29:0], 2'b00};
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mips_single_cycle_core.sv
// Bench for mips_single_cycle_core: architectural model vs DUT state,
// plus hand-computed literal checks on the directed programs.

module tb_mips_single_cycle_core;
  logic clk = 1'b0;
  logic reset = 1'b0;

  int nerr = 0;
  int nchk = 0;

  logic [31:0] m_imem [256];
  logic [31:0] m_dmem [256];
  logic [31:0] m_regs [32];
  logic [31:0] m_pc;

  mips_single_cycle_core dut (
    .clk   (clk),
    .reset (reset)
  );

  always #5 clk = ~clk;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_reg(int i, logic [31:0] v);
    dut.register_file_inst.registers[i] = v;
    m_regs[i] = v;
  endtask

  task automatic set_imem(int i, logic [31:0] v);
    dut.instruction_memory_inst.memory[i] = v;
    m_imem[i] = v;
  endtask

  task automatic set_dmem(int i, logic [31:0] v);
    dut.data_memory_inst.memory[i] = v;
    m_dmem[i] = v;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) set_imem(i, 32'd0);
  endtask

  // Architectural effect of one instruction on the model state
  task automatic model_step();
    logic [31:0] w, a, b, simm, npc, res, ea, idx;
    logic [4:0]  dst;
    logic        wr;
    idx  = m_pc >> 2;
    w    = (idx < 256) ? m_imem[idx[7:0]] : 32'd0;
    a    = m_regs[w[25:21]];
    b    = m_regs[w[20:16]];
    simm = {{16{w[15]}}, w[15:0]};
    ea   = a + simm;
    npc  = m_pc + 4;
    res  = 0;
    dst  = 0;
    wr   = 0;
    case (w[31:26])
      6'd0: begin
        dst = w[15:11];
        wr  = 1;
        case (w[5:0])
          6'h20: res = a + b;
          6'h22: res = a - b;
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h2a: res = ($signed(a) < $signed(b)) ? 1 : 0;
          default: wr = 0;
        endcase
      end
      6'h23: begin
        dst = w[20:16];
        wr  = 1;
        res = (ea < 256) ? m_dmem[ea[7:0]] : 0;
      end
      6'h2b: if (ea < 256) m_dmem[ea[7:0]] = b;
      6'h04: if (a == b) npc = npc + (simm << 2);
      6'h08: begin
        dst = w[20:16];
        wr  = 1;
        res = a + simm;
      end
      6'h02: npc = {npc[31:28], w[25:0], 2'b00};
      default: ;
    endcase
    if (wr && dst != 0) m_regs[dst] = res;
    m_pc = npc;
  endtask

  task automatic compare_state(string tag);
    int bad;
    check({tag, " pc"}, dut.pc_inst.pc_out, m_pc);
    for (int i = 0; i < 32; i++)
      check($sformatf("%s r%0d", tag, i),
            dut.register_file_inst.registers[i], m_regs[i]);
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (dut.data_memory_inst.memory[i] !== m_dmem[i]) bad++;
    check({tag, " dmem_diffs"}, 32'(bad), 32'd0);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_state("step");
    @(negedge clk);
  endtask

  // Assert reset at a negedge, check the asynchronous clear, hold 2 edges
  task automatic do_reset();
    int bad;
    reset = 1'b1;
    m_pc = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = 0;
    #1;
    compare_state("rst");
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (dut.instruction_memory_inst.memory[i] !== m_imem[i]) bad++;
    check("rst imem_diffs", 32'(bad), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      set_imem(i, 32'd0);
      set_dmem(i, 32'd0);
    end
    @(negedge clk);
    do_reset();
    check("reset pc lit", dut.pc_inst.pc_out, 32'd0);
    reset = 1'b0;
    repeat (3) step();
    check("nop pc lit", dut.pc_inst.pc_out, 32'd12);

    // add then sub
    do_reset();
    set_reg(3, 32'd2);
    set_reg(4, 32'd3);
    set_reg(5, 32'd1);
    set_imem(0, 32'h00641020);
    set_imem(1, 32'h00851822);
    reset = 1'b0;
    step();
    check("add r2 lit", dut.register_file_inst.registers[2], 32'd5);
    check("add pc lit", dut.pc_inst.pc_out, 32'd4);
    step();
    check("sub r3 lit", dut.register_file_inst.registers[3], 32'd2);

    // lw then sw
    do_reset();
    clear_imem();
    set_dmem(4, 32'd10);
    set_reg(2, 32'd20);
    set_imem(0, 32'h8C040004);
    set_imem(1, 32'hAC02000A);
    reset = 1'b0;
    step();
    check("lw r4 lit", dut.register_file_inst.registers[4], 32'd10);
    step();
    check("sw dmem10 lit", dut.data_memory_inst.memory[10], 32'd20);

    // beq taken
    do_reset();
    clear_imem();
    set_reg(1, 32'd5);
    set_reg(2, 32'd5);
    set_imem(4, 32'h10220004);
    reset = 1'b0;
    repeat (5) step();
    check("beq taken lit", dut.pc_inst.pc_out, 32'd36);

    // beq not taken
    do_reset();
    set_reg(1, 32'd5);
    set_reg(2, 32'd6);
    reset = 1'b0;
    repeat (5) step();
    check("beq fall lit", dut.pc_inst.pc_out, 32'd20);

    // back-to-back program with $0 write and jump
    do_reset();
    clear_imem();
    set_imem(0, 32'h2001FFFF);
    set_imem(1, 32'h0020102A);
    set_imem(2, 32'h00221824);
    set_imem(3, 32'h00402025);
    set_imem(4, 32'h00210020);
    set_imem(5, 32'h08000000);
    reset = 1'b0;
    repeat (6) step();
    check("prog r1 lit", dut.register_file_inst.registers[1], 32'hFFFFFFFF);
    check("prog r2 lit", dut.register_file_inst.registers[2], 32'd1);
    check("prog r3 lit", dut.register_file_inst.registers[3], 32'd1);
    check("prog r4 lit", dut.register_file_inst.registers[4], 32'd1);
    check("prog r0 lit", dut.register_file_inst.registers[0], 32'd0);
    check("prog jpc lit", dut.pc_inst.pc_out, 32'd0);

    // mid-program reset at PC=12
    repeat (3) step();
    check("mid pc lit", dut.pc_inst.pc_out, 32'd12);
    do_reset();
    check("mid rst pc lit", dut.pc_inst.pc_out, 32'd0);
    check("mid rst r1 lit", dut.register_file_inst.registers[1], 32'd0);
    check("mid imem0 lit",
          dut.instruction_memory_inst.memory[0], 32'h2001FFFF);
    check("mid dmem10 lit", dut.data_memory_inst.memory[10], 32'd20);

    // out-of-range data address: store dropped, load reads zero
    clear_imem();
    set_reg(6, 32'd7);
    set_imem(0, 32'h2005012C);
    set_imem(1, 32'hACA50000);
    set_imem(2, 32'h8CA60000);
    reset = 1'b0;
    repeat (3) step();
    check("oor r6 lit", dut.register_file_inst.registers[6], 32'd0);
    check("oor dmem44 lit", dut.data_memory_inst.memory[44], 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
